sequence_gen: RTL and testbench
===============================

Name: sequence_gen

Overview:
Serial pattern transmitter. It is the sending end of the team's serial bit-sequence detectors.
- Loads a parallel pattern of programmable length and shifts it out one bit per clock, MSB first.
- Optionally repeats the pattern, with idle-zero gaps between repetitions.
- Drives detector inputs in lab benches and on-board stimulus paths.
- Start/busy/done handshake toward the controlling logic.

Parameters:
MAX_LEN, 16, maximum pattern length in bits; pattern port width.
LEN_W, 5, width of len port; must hold MAX_LEN.
REP_W, 4, width of rep port (extra repetitions, 0..2^REP_W-1).
GAP_CYC, 2, idle cycles (out=0, valid=0) between repetitions; 0 allowed.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
abort  input  1  synchronous cancel; wins over everything except rst
pattern  input  MAX_LEN  bits to send; bit len-1 goes out first
len  input  LEN_W  number of bits to send, legal 1..MAX_LEN
rep  input  REP_W  extra repetitions; total sends = rep+1
out  output  1  serial data bit
valid  output  1  high while out carries a pattern bit
busy  output  1  high from the cycle after accepted start until return to IDLE
done  output  1  one-cycle pulse after the final bit of the final repetition
err  output  1  one-cycle pulse when start is rejected for an illegal len

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: out=0, valid=0, busy=0, done=0, err=0. State is IDLE; internal shift, bit and repeat counters are cleared.
- States: IDLE, SEND, GAP, DONE. Encoding is free; no unreachable state may lock up, and any illegal state goes to IDLE.
- IDLE, start=1, len in 1..MAX_LEN:
  - Capture pattern, len and rep into internal registers. Later changes on these inputs have no effect until the next IDLE.
  - Next cycle: state=SEND, busy=1, valid=1, out=pattern[len-1].
- IDLE, start=1, len=0 or len>MAX_LEN:
  - Nothing is captured; state stays IDLE.
  - err=1 for exactly one cycle; busy stays 0.
- SEND:
  - One bit per cycle, descending index, down to bit 0.
  - Exactly len consecutive valid cycles per repetition.
- End of a repetition (bit 0 is on out in the current cycle):
  - If repetitions remain and GAP_CYC>0: GAP for exactly GAP_CYC cycles with out=0 and valid=0, then SEND restarts at bit len-1.
  - If repetitions remain and GAP_CYC=0: the next cycle is the MSB of the next repetition, with no bubble.
  - If none remain: DONE.
- DONE lasts one cycle:
  - done=1, busy=1, valid=0, out=0.
  - The next cycle is IDLE with busy=0.
- start while busy: ignored, not queued.
- start in the same cycle as the DONE pulse: ignored. A new start is accepted on the first IDLE cycle.
- Latency:
  - Accepted start at cycle T → first bit at T+1.
  - done at T+1+(rep+1)*len+rep*GAP_CYC.
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE: out=0, valid=0, busy=0.
  - done does not fire; err does not fire.
- abort=1 in IDLE: no effect, and it also suppresses a simultaneous start.
- rst mid-transfer: outputs take their reset values on the next edge; no done.
- Counter widths: the bit counter is sized for MAX_LEN and the repeat counter is REP_W wide. No wrap is possible for legal inputs; rep=2^REP_W-1 must give exactly 2^REP_W sends.

Test Plan:
- pattern=16'h000F, len=4, rep=0, start at T → out=1,1,1,1 with valid=1 at T+1..T+4; done=1 at T+5; busy=0 at T+6.
- pattern=16'h000B, len=4, rep=2, GAP_CYC=2 → out stream 1011,00,1011,00,1011; valid low only in the four gap cycles; done at T+17.
- len=0 with start, then len=17 with start → err pulse for each, one cycle each; busy, valid and done stay 0.
- pattern=16'hFFFF, len=16, rep=0; abort asserted on the 5th valid cycle → next cycle out=0, valid=0, busy=0; no done pulse; an immediate new start with len=1 sends a single bit.
- start held high throughout a len=3 transfer, and pattern changed mid-transfer → only the captured pattern is sent; exactly one transfer before the DONE pulse; the second transfer starts on the first IDLE cycle.
- GAP_CYC=0 build, pattern=16'h0002, len=2, rep=3 → out=1,0,1,0,1,0,1,0 with valid continuously high for 8 cycles; rst pulsed on the 3rd bit → all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/sequence_gen.sv
// ----------------------------------------------------------------------------
// sequence_gen
//   Serial pattern transmitter. It captures a parallel pattern of programmable
//   length and shifts it out MSB first, one bit per clock. The pattern can be
//   repeated, with idle-zero gap cycles between repetitions. A start/busy/done
//   handshake faces the controlling logic. All outputs are registered.
//
// Parameters
//   MAX_LEN  maximum pattern length in bits (width of pattern)
//   LEN_W    width of len, must be able to hold MAX_LEN
//   REP_W    width of rep (number of extra repetitions)
//   GAP_CYC  idle cycles between repetitions (0 = back-to-back)
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous reset, active high
//   start    transfer request, sampled only while idle
//   abort    synchronous cancel, overrides everything except rst
//   pattern  bits to send; bit len-1 goes out first
//   len      number of bits per repetition, legal 1..MAX_LEN
//   rep      extra repetitions; total sends = rep+1
//   out      serial data bit
//   valid    high while out carries a pattern bit
//   busy     high from the cycle after an accepted start until back in idle
//   done     one-cycle pulse after the last bit of the last repetition
//   err      one-cycle pulse when start is rejected for an illegal len
// ----------------------------------------------------------------------------
module sequence_gen #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int REP_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [REP_W-1:0]   rep,
    output logic               out,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int BIT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [BIT_W-1:0]   top_q, top_d;   // index of the MSB to send (len-1)
    logic [BIT_W-1:0]   bit_q, bit_d;   // index of the bit currently on out
    logic [REP_W-1:0]   rep_q, rep_d;   // repetitions still to send
    logic [GAP_W-1:0]   gap_q, gap_d;   // gap cycles remaining after this one
    logic               out_q, out_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               len_ok;
    logic [LEN_W-1:0]   len_m1;
    logic [BIT_W-1:0]   len_top;
    logic [BIT_W-1:0]   bit_dec;

    // len is only used as an index once it is known to be in 1..MAX_LEN,
    // so truncating len-1 to the bit-index width is lossless there.
    assign len_ok  = (len != '0) && (32'(len) <= MAX_LEN);
    assign len_m1  = len - 1'b1;
    assign len_top = BIT_W'(len_m1);
    assign bit_dec = bit_q - 1'b1;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        top_d   = top_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort in idle swallows a simultaneous start (and its err)
                if (start && !abort) begin
                    if (len_ok) begin
                        state_d = S_SEND;
                        pat_d   = pattern;
                        top_d   = len_top;
                        rep_d   = rep;
                        bit_d   = len_top;
                        out_d   = pattern[len_top];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_SEND: begin
                busy_d = 1'b1;
                if (bit_q != '0) begin
                    bit_d   = bit_dec;
                    out_d   = pat_q[bit_dec];
                    valid_d = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d = rep_q - 1'b1;
                    if (GAP_CYC > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_W'(GAP_CYC - 1);
                    end else begin
                        // no gap: MSB of the next repetition follows bit 0
                        bit_d   = top_q;
                        out_d   = pat_q[top_q];
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

            S_GAP: begin
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    state_d = S_SEND;
                    bit_d   = top_q;
                    out_d   = pat_q[top_q];
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            S_DONE: begin
                // start during the done pulse is deliberately not looked at
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            out_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            top_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            top_q   <= top_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_sequence_gen.sv
// ----------------------------------------------------------------------------
// tb_sequence_gen
//   Two transmitters share one stimulus stream: one built with a two-cycle gap
//   between repetitions, one with no gap. A reference model predicts every
//   output cycle from the transfer parameters by plain arithmetic on the
//   cycle offset since the accepted start; directed sequences add literal
//   expectations on top.
// ----------------------------------------------------------------------------
module tb_sequence_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic [3:0]  rep;

    logic out_a, valid_a, busy_a, done_a, err_a;
    logic out_b, valid_b, busy_b, done_b, err_b;

    always #5 clk = ~clk;

    sequence_gen #(.MAX_LEN(16), .LEN_W(5), .REP_W(4), .GAP_CYC(2)) dut_gap2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .rep(rep),
        .out(out_a), .valid(valid_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    sequence_gen #(.MAX_LEN(16), .LEN_W(5), .REP_W(4), .GAP_CYC(0)) dut_gap0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .len(len), .rep(rep),
        .out(out_b), .valid(valid_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // observation layout: {out, valid, busy, done, err}
    typedef struct packed {
        logic o_out;
        logic o_valid;
        logic o_busy;
        logic o_done;
        logic o_err;
    } obs_t;

    wire [4:0] obs_a = {out_a, valid_a, busy_a, done_a, err_a};
    wire [4:0] obs_b = {out_b, valid_b, busy_b, done_b, err_b};

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs k cycles after the cycle in which start was accepted.
    function automatic obs_t expect_at(input logic [15:0] pat, input int l, input int r,
                                       input int gap, input int k);
        obs_t o;
        int   period;
        int   total;
        int   pos;
        o      = '0;
        period = l + gap;
        total  = (r + 1) * l + r * gap;
        if (k >= 1 && k <= total) begin
            pos    = (k - 1) % period;
            o.o_busy = 1'b1;
            if (pos < l) begin
                o.o_valid = 1'b1;
                o.o_out   = pat[l - 1 - pos];
            end
        end else if (k == total + 1) begin
            o.o_busy = 1'b1;
            o.o_done = 1'b1;
        end
        return o;
    endfunction

    // Reference model, index 0 = gap 2 build, index 1 = gap 0 build.
    obs_t        cur   [2];
    logic [15:0] m_pat [2];
    int          m_len [2];
    int          m_rep [2];
    int          m_k   [2];

    always @(posedge clk) begin
        obs_t nx;
        int   gp;
        for (int g = 0; g < 2; g++) begin
            gp = (g == 0) ? 2 : 0;
            nx = '0;
            if (rst) begin
                m_k[g] <= 0;
            end else if (cur[g].o_busy === 1'b1) begin
                if (!abort) begin
                    nx     = expect_at(m_pat[g], m_len[g], m_rep[g], gp, m_k[g] + 1);
                    m_k[g] <= m_k[g] + 1;
                end
            end else if (start && !abort) begin
                if (len >= 5'd1 && len <= 5'd16) begin
                    m_pat[g] <= pattern;
                    m_len[g] <= int'(len);
                    m_rep[g] <= int'(rep);
                    m_k[g]   <= 1;
                    nx       = expect_at(pattern, int'(len), int'(rep), gp, 1);
                end else begin
                    nx.o_err = 1'b1;
                end
            end
            cur[g] <= nx;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle gap2", {27'd0, obs_a}, {27'd0, cur[0]});
            chk("cycle gap0", {27'd0, obs_b}, {27'd0, cur[1]});
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_out2, exp_val2;
    logic [11:0] exp_out0;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        len     = '0;
        rep     = '0;
        step;
        chk_en = 1'b1;
        chk("reset gap2", {27'd0, obs_a}, 32'd0);
        chk("reset gap0", {27'd0, obs_b}, 32'd0);
        rst = 1'b0;
        step;

        // pin the model itself against hand-worked values
        chk("model gap slot", {27'd0, expect_at(16'h000B, 4, 2, 2, 5)}, 32'b00100);
        chk("model done", {27'd0, expect_at(16'h000B, 4, 2, 2, 17)}, 32'b00110);
        chk("model nogap msb", {27'd0, expect_at(16'h000B, 4, 2, 0, 5)}, 32'b11100);

        // single 4-bit send of ones
        pattern = 16'h000F; len = 5'd4; rep = 4'd0; start = 1'b1;
        step;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1 bit gap2", {27'd0, obs_a}, 32'b11100);
            chk("t1 bit gap0", {27'd0, obs_b}, 32'b11100);
            step;
        end
        chk("t1 done", {27'd0, obs_a}, 32'b00110);
        step;
        chk("t1 idle", {27'd0, obs_a}, 32'd0);
        step;

        // repeated pattern with and without gap
        exp_out2 = 16'b1011_0010_1100_1011;
        exp_val2 = 16'b1111_0011_1100_1111;
        exp_out0 = 12'b1011_1011_1011;
        pattern = 16'h000B; len = 5'd4; rep = 4'd2; start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            if (k <= 16)
                chk("t2 gap2 out/valid", {30'd0, out_a, valid_a},
                    {30'd0, exp_out2[16-k], exp_val2[16-k]});
            else
                chk("t2 gap2 done", {31'd0, done_a}, 32'd1);
            if (k <= 12)
                chk("t2 gap0 out/valid", {30'd0, out_b, valid_b}, {30'd0, exp_out0[12-k], 1'b1});
            else if (k == 13)
                chk("t2 gap0 done", {31'd0, done_b}, 32'd1);
            step;
        end
        step;

        // illegal lengths
        len = 5'd0; start = 1'b1;
        step;
        chk("t3 err len0", {27'd0, obs_a}, 32'b00001);
        start = 1'b0;
        step;
        chk("t3 err clears", {27'd0, obs_a}, 32'd0);
        len = 5'd17; start = 1'b1;
        step;
        chk("t3 err len17", {27'd0, obs_b}, 32'b00001);
        start = 1'b0;
        step;
        chk("t3 err clears 17", {27'd0, obs_b}, 32'd0);

        // abort on the fifth bit, then an immediate one-bit send
        pattern = 16'hFFFF; len = 5'd16; rep = 4'd0; start = 1'b1;
        step;
        start = 1'b0;
        step; step; step; step;
        chk("t4 fifth bit", {27'd0, obs_a}, 32'b11100);
        abort = 1'b1;
        step;
        abort = 1'b0;
        chk("t4 abort gap2", {27'd0, obs_a}, 32'd0);
        chk("t4 abort gap0", {27'd0, obs_b}, 32'd0);
        pattern = 16'h0001; len = 5'd1; start = 1'b1;
        step;
        start = 1'b0;
        chk("t4 one bit", {27'd0, obs_a}, 32'b11100);
        step;
        chk("t4 one bit done", {27'd0, obs_a}, 32'b00110);
        step;
        chk("t4 idle", {27'd0, obs_a}, 32'd0);

        // start held, pattern changed mid-transfer
        pattern = 16'h0005; len = 5'd3; rep = 4'd0; start = 1'b1;
        step;
        chk("t5 bit2", {27'd0, obs_a}, 32'b11100);
        pattern = 16'h0002;
        step;
        chk("t5 bit1", {27'd0, obs_a}, 32'b01100);
        step;
        chk("t5 bit0", {27'd0, obs_a}, 32'b11100);
        step;
        chk("t5 done", {27'd0, obs_a}, 32'b00110);
        step;
        chk("t5 idle gap", {27'd0, obs_a}, 32'd0);
        step;
        chk("t5 second msb", {27'd0, obs_a}, 32'b01100);
        start = 1'b0;
        step; step; step; step;

        // back-to-back repetitions in the no-gap build, then reset mid-send
        pattern = 16'h0002; len = 5'd2; rep = 4'd3; start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("t6 gap0 stream", {27'd0, obs_b}, {27'd0, k[0], 4'b1100});
            step;
        end
        chk("t6 gap0 done", {27'd0, obs_b}, 32'b00110);
        for (int k = 0; k < 7; k++) step;
        start = 1'b1;
        step;
        start = 1'b0;
        step; step;
        chk("t6 third bit", {27'd0, obs_b}, 32'b11100);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("t6 rst gap2", {27'd0, obs_a}, 32'd0);
        chk("t6 rst gap0", {27'd0, obs_b}, 32'd0);
        step;

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            abort   = ($urandom_range(0, 59) == 0);
            start   = ($urandom_range(0, 3) == 0);
            pattern = 16'($urandom);
            if ($urandom_range(0, 9) == 0)
                len = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
            else
                len = 5'($urandom_range(1, 16));
            rep = ($urandom_range(0, 19) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            step;
        end
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        step; step;
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
